fast_serial_cmd_bridge: RTL and testbench

- Parametrised byte-stream command bridge between the fast-serial byte streams and an internal register bank.
- Parses framed write/read commands from the inbound byte stream and updates a NUM_REGS x (8*DATA_BYTES) register file.
- Register 0 drives the LED/GPIO output.
- Returns a status/data response frame on the outbound byte stream with full ready/valid backpressure.
- Adds inter-byte timeout recovery and an optional frame checksum.

---
 rtl/fast_serial_cmd_bridge_pkg.sv | 18 +
 rtl/fast_serial_cmd_bridge_if.sv | 22 ++
 rtl/fast_serial_cmd_bridge_resp_tx.sv | 74 +++++++
 rtl/fast_serial_cmd_bridge.sv | 195 +++++++++++++++++++
 tb/tb_fast_serial_cmd_bridge.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_serial_cmd_bridge_pkg.sv
// Shared constants and parser state type for the fast-serial command bridge.
// The CSUM state only exists when FAST_SERIAL_CSUM_EN is defined.
package fast_serial_pkg;

    localparam logic [7:0] CMD_WR       = 8'h01;
    localparam logic [7:0] CMD_RD       = 8'h02;
    localparam logic [7:0] RSP_WR_OK    = 8'h81;
    localparam logic [7:0] RSP_RD_OK    = 8'h82;
    localparam logic [7:0] RSP_ERR      = 8'hEE;
    localparam logic [7:0] RSP_CSUM_ERR = 8'hEC;

`ifdef FAST_SERIAL_CSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_WDATA, ST_CSUM, ST_RESP} parse_state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_WDATA, ST_RESP} parse_state_t;
`endif

endpackage

// File: rtl/fast_serial_cmd_bridge_if.sv
// Inbound and outbound byte-stream handshakes of the bridge.
// The master is the host side; the slave is the bridge itself.
interface fast_serial_cmd_bridge_if;

    logic       in_bytes_stream_valid;
    logic       in_bytes_stream_ready;
    logic [7:0] in_bytes_stream_data;
    logic       out_bytes_stream_valid;
    logic       out_bytes_stream_ready;
    logic [7:0] out_bytes_stream_data;

    modport master (
        output in_bytes_stream_valid, in_bytes_stream_data, out_bytes_stream_ready,
        input  in_bytes_stream_ready, out_bytes_stream_valid, out_bytes_stream_data
    );

    modport slave (
        input  in_bytes_stream_valid, in_bytes_stream_data, out_bytes_stream_ready,
        output in_bytes_stream_ready, out_bytes_stream_valid, out_bytes_stream_data
    );

endinterface

// File: rtl/fast_serial_cmd_bridge_resp_tx.sv
// Response serializer: loads a header, optional data and (with FAST_SERIAL_CSUM_EN)
// a trailing XOR byte, then shifts them out under ready/valid.
module fast_serial_resp_tx #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [7:0]              hdr,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    with_data,
    output logic                    valid,
    input  logic                    ready,
    output logic [7:0]              out_data,
    output logic                    done
);

`ifdef FAST_SERIAL_CSUM_EN
    localparam int NB = DATA_BYTES + 2;
`else
    localparam int NB = DATA_BYTES + 1;
`endif
    localparam int CW = $clog2(NB + 1);

    logic [7:0]    bytes_q [NB];
    logic [7:0]    ld      [NB];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] ld_len;
    logic          accept;
`ifdef FAST_SERIAL_CSUM_EN
    logic [7:0]    csum;
`endif

    // Byte image of the frame as it will leave, header first.
    always_comb begin
        for (int i = 0; i < NB; i++) ld[i] = 8'h00;
        ld[0]  = hdr;
        ld_len = CW'(1);
        if (with_data) begin
            for (int k = 0; k < DATA_BYTES; k++) ld[1+k] = data[8*(DATA_BYTES-1-k) +: 8];
            ld_len = CW'(DATA_BYTES + 1);
        end
`ifdef FAST_SERIAL_CSUM_EN
        csum = hdr;
        if (with_data) begin
            for (int k = 0; k < DATA_BYTES; k++) csum = csum ^ ld[1+k];
            ld[NB-1] = csum;
        end else begin
            ld[1] = csum;
        end
        ld_len = ld_len + CW'(1);
`endif
    end

    assign valid    = (cnt_q != '0);
    assign out_data = bytes_q[0];
    assign accept   = valid && ready;
    assign done     = accept && (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < NB; i++) bytes_q[i] <= 8'h00;
        end else if (load) begin
            cnt_q   <= ld_len;
            bytes_q <= ld;
        end else if (accept) begin
            cnt_q <= cnt_q - CW'(1);
            for (int i = 0; i < NB - 1; i++) bytes_q[i] <= bytes_q[i+1];
            bytes_q[NB-1] <= 8'h00;
        end
    end

endmodule

// File: rtl/fast_serial_cmd_bridge.sv
// Framed write/read command parser over a register bank with inter-byte timeout.
// Define FAST_SERIAL_CSUM_EN to add XOR checksums to inbound and outbound frames.
module fast_serial_cmd_bridge
    import fast_serial_pkg::*;
#(
    parameter int DATA_BYTES     = 4,
    parameter int NUM_REGS       = 8,
    parameter int GPIO_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk_clk,
    input  logic                             reset_reset,
    fast_serial_cmd_bridge_if.slave          bus,
    output logic [GPIO_W-1:0]                led_gpio_led,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] regs_flat,
    output logic                             frame_err
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    parse_state_t  state_q, state_n;
    logic          is_wr_q;
    logic [7:0]    addr_q;
    logic [7:0]    bcnt_q;
    logic [DW-1:0] wdata_q;
    logic [31:0]   tcnt_q;
    logic [DW-1:0] regs [NUM_REGS];
`ifdef FAST_SERIAL_CSUM_EN
    logic [7:0]    csum_q;
`endif

    logic          accept, mid, expire, finish, addr_ok;
    logic          load, with_data, do_write, err_n, tx_done;
    logic [7:0]    in_byte, hdr, fin_addr;
    logic [DW-1:0] wshift, fin_wdata, rdata;

    assign in_byte                   = bus.in_bytes_stream_data;
    assign bus.in_bytes_stream_ready = !reset_reset && (state_q != ST_RESP);
    assign accept                    = bus.in_bytes_stream_valid && bus.in_bytes_stream_ready;
`ifdef FAST_SERIAL_CSUM_EN
    assign mid = (state_q == ST_ADDR) || (state_q == ST_WDATA) || (state_q == ST_CSUM);
`else
    assign mid = (state_q == ST_ADDR) || (state_q == ST_WDATA);
`endif
    assign expire = (TIMEOUT_CYCLES != 0) && mid && (tcnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wshift      = wdata_q << 8;
        wshift[7:0] = in_byte;
    end

    // The last frame byte may be the address or data byte arriving this cycle.
    assign fin_addr  = (state_q == ST_ADDR) ? in_byte : addr_q;
    assign fin_wdata = (state_q == ST_WDATA) ? wshift : wdata_q;
    assign addr_ok   = ({1'b0, fin_addr} < 9'(NUM_REGS));
    assign rdata     = regs[fin_addr[AW-1:0]];

    always_comb begin
        state_n   = state_q;
        load      = 1'b0;
        hdr       = RSP_ERR;
        with_data = 1'b0;
        do_write  = 1'b0;
        err_n     = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (in_byte == CMD_WR || in_byte == CMD_RD) begin
                    state_n = ST_ADDR;
                end else begin
                    load    = 1'b1;
                    err_n   = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_ADDR: if (accept) begin
                if (is_wr_q) begin
                    state_n = ST_WDATA;
                end else begin
`ifdef FAST_SERIAL_CSUM_EN
                    state_n = ST_CSUM;
`else
                    finish = 1'b1;
`endif
                end
            end
            ST_WDATA: if (accept && bcnt_q == 8'(DATA_BYTES - 1)) begin
`ifdef FAST_SERIAL_CSUM_EN
                state_n = ST_CSUM;
`else
                finish = 1'b1;
`endif
            end
`ifdef FAST_SERIAL_CSUM_EN
            ST_CSUM: if (accept) begin
                if (in_byte != csum_q) begin
                    load    = 1'b1;
                    hdr     = RSP_CSUM_ERR;
                    err_n   = 1'b1;
                    state_n = ST_RESP;
                end else begin
                    finish = 1'b1;
                end
            end
`endif
            ST_RESP: if (tx_done) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (finish) begin
            load    = 1'b1;
            state_n = ST_RESP;
            if (!addr_ok) begin
                err_n = 1'b1;
            end else if (is_wr_q) begin
                hdr      = RSP_WR_OK;
                do_write = 1'b1;
            end else begin
                hdr       = RSP_RD_OK;
                with_data = 1'b1;
            end
        end
        if (!accept && expire) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= 8'h00;
            bcnt_q    <= 8'h00;
            wdata_q   <= '0;
            tcnt_q    <= 32'd0;
            frame_err <= 1'b0;
`ifdef FAST_SERIAL_CSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_n;
            frame_err <= err_n;
            if (accept) begin
                tcnt_q <= 32'd0;
`ifdef FAST_SERIAL_CSUM_EN
                csum_q <= (state_q == ST_IDLE) ? in_byte : (csum_q ^ in_byte);
`endif
                case (state_q)
                    ST_IDLE:  is_wr_q <= (in_byte == CMD_WR);
                    ST_ADDR: begin
                        addr_q <= in_byte;
                        bcnt_q <= 8'h00;
                    end
                    ST_WDATA: begin
                        wdata_q <= wshift;
                        bcnt_q  <= bcnt_q + 8'd1;
                    end
                    default: ;
                endcase
            end else if (mid) begin
                tcnt_q <= tcnt_q + 32'd1;
            end else begin
                tcnt_q <= 32'd0;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (do_write) begin
            regs[fin_addr[AW-1:0]] <= fin_wdata;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DW +: DW] = regs[g];
    end
    assign led_gpio_led = regs[0][GPIO_W-1:0];

    fast_serial_resp_tx #(.DATA_BYTES(DATA_BYTES)) u_resp_tx (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .load      (load),
        .hdr       (hdr),
        .data      (rdata),
        .with_data (with_data),
        .valid     (bus.out_bytes_stream_valid),
        .ready     (bus.out_bytes_stream_ready),
        .out_data  (bus.out_bytes_stream_data),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_fast_serial_cmd_bridge.sv
// Scoreboard bench for fast_serial_cmd_bridge: directed frames, timeout, reset, then random traffic.
// Build with FAST_SERIAL_CSUM_EN defined to exercise the checksum variant.
module tb_fast_serial_cmd_bridge;
    import fast_serial_pkg::*;

    localparam int DB = 4;
    localparam int NR = 8;
    localparam int TO = 16;
`ifdef FAST_SERIAL_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fast_serial_cmd_bridge_if bus();
    logic [7:0]           led;
    logic [NR*DB*8-1:0]   regs_flat;
    logic                 frame_err;

    fast_serial_cmd_bridge #(
        .DATA_BYTES(DB), .NUM_REGS(NR), .GPIO_W(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .bus          (bus),
        .led_gpio_led (led),
        .regs_flat    (regs_flat),
        .frame_err    (frame_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          err_exp = 0;
    int          err_seen = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] model[NR];
    bit          always_ready = 1'b1;
    bit          stall_pending = 1'b0;
    logic [7:0]  stall_data;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Output-side monitor: pops the scoreboard, checks stall stability and in_ready in RESP.
    always @(negedge clk) begin
        if (rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                checks++;
                if (!(bus.out_bytes_stream_valid && bus.out_bytes_stream_data == stall_data)) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%0b data=%0h, expected valid=1 data=%0h",
                             bus.out_bytes_stream_valid, bus.out_bytes_stream_data, stall_data);
                end
            end
            if (bus.out_bytes_stream_valid) begin
                check_output("in_ready_in_resp", bus.in_bytes_stream_ready, 0);
            end
            if (bus.out_bytes_stream_valid && bus.out_bytes_stream_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got %0h, expected no byte", bus.out_bytes_stream_data);
                end else begin
                    check_output("resp_byte", bus.out_bytes_stream_data, exp_q.pop_front());
                end
                stall_pending = 1'b0;
            end else if (bus.out_bytes_stream_valid) begin
                stall_pending = 1'b1;
                stall_data    = bus.out_bytes_stream_data;
            end else begin
                stall_pending = 1'b0;
            end
            if (frame_err) err_seen++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        bus.out_bytes_stream_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        bus.in_bytes_stream_valid = 1'b1;
        bus.in_bytes_stream_data  = b;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (bus.in_bytes_stream_ready) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        bus.in_bytes_stream_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_accept_timeout: got no accept, expected byte %0h accepted", b);
        end
    endtask

    // Builds one frame, predicts the response from the register model, then sends it.
    task automatic apply_stimulus(input logic [7:0] cmd, input logic [7:0] addr,
                                  input logic [31:0] data, input bit corrupt);
        logic [7:0] fr[$];
        logic [7:0] resp[$];
        logic [7:0] x;
        fr.push_back(cmd);
        if (cmd == CMD_WR || cmd == CMD_RD) begin
            fr.push_back(addr);
            if (cmd == CMD_WR) for (int k = DB - 1; k >= 0; k--) fr.push_back(data[8*k +: 8]);
            if (CSUM) begin
                x = 8'h00;
                foreach (fr[i]) x = x ^ fr[i];
                fr.push_back(corrupt ? (x ^ 8'h5A) : x);
            end
        end
        if (cmd != CMD_WR && cmd != CMD_RD) begin
            resp.push_back(RSP_ERR);
            err_exp++;
        end else if (CSUM && corrupt) begin
            resp.push_back(RSP_CSUM_ERR);
            err_exp++;
        end else if (addr >= NR) begin
            resp.push_back(RSP_ERR);
            err_exp++;
        end else if (cmd == CMD_WR) begin
            model[addr] = data;
            resp.push_back(RSP_WR_OK);
        end else begin
            resp.push_back(RSP_RD_OK);
            for (int k = DB - 1; k >= 0; k--) resp.push_back(model[addr][8*k +: 8]);
        end
        if (CSUM) begin
            x = 8'h00;
            foreach (resp[i]) x = x ^ resp[i];
            resp.push_back(x);
        end
        foreach (resp[i]) exp_q.push_back(resp[i]);
        foreach (fr[i]) begin
            if (i != 0 && !always_ready) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            send_byte(fr[i]);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_output("drain_left", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++) check_output($sformatf("reg%0d", i), regs_flat[32*i +: 32], model[i]);
        check_output("led", led, model[0][7:0]);
        check_output("frame_err_count", err_seen, err_exp);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] c;
        int r;
        bus.in_bytes_stream_valid  = 1'b0;
        bus.in_bytes_stream_data   = 8'h00;
        bus.out_bytes_stream_ready = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        repeat (3) @(negedge clk);
        check_output("rst_in_ready", bus.in_bytes_stream_ready, 0);
        check_output("rst_out_valid", bus.out_bytes_stream_valid, 0);
        check_output("rst_out_data", bus.out_bytes_stream_data, 0);
        check_output("rst_frame_err", frame_err, 0);
        check_output("rst_regs", regs_flat == '0, 1);
        rst = 1'b0;
        #1;
        check_output("post_rst_in_ready", bus.in_bytes_stream_ready, 1);
        @(posedge clk);
        #1;

        apply_stimulus(CMD_WR, 8'h00, 32'h12345678, 1'b0);
        check_output("wr_latency_valid", bus.out_bytes_stream_valid, 1);
        check_output("wr_latency_in_ready", bus.in_bytes_stream_ready, 0);
        wait_drain();
        check_regs();

        apply_stimulus(CMD_WR, 8'h03, 32'hDEADBEEF, 1'b0);
        wait_drain();
        always_ready = 1'b0;
        apply_stimulus(CMD_RD, 8'h03, 32'h0, 1'b0);
        wait_drain();
        apply_stimulus(CMD_RD, 8'h08, 32'h0, 1'b0);
        wait_drain();
        apply_stimulus(CMD_WR, 8'h09, 32'hCAFEF00D, 1'b0);
        wait_drain();
        apply_stimulus(8'h7F, 8'h00, 32'h0, 1'b0);
        wait_drain();
        apply_stimulus(CMD_RD, 8'h00, 32'h0, 1'b0);
        wait_drain();
        check_regs();

        send_byte(CMD_WR);
        send_byte(8'h02);
        send_byte(8'hAA);
        err_exp++;
        repeat (TO + 6) @(posedge clk);
        #1;
        check_output("timeout_no_resp", exp_q.size(), 0);
        check_regs();
        apply_stimulus(CMD_RD, 8'h02, 32'h0, 1'b0);
        wait_drain();

        if (CSUM) begin
            apply_stimulus(CMD_WR, 8'h01, 32'h00000005, 1'b0);
            wait_drain();
            apply_stimulus(CMD_WR, 8'h01, 32'h00000077, 1'b1);
            wait_drain();
            check_regs();
        end

        send_byte(CMD_WR);
        send_byte(8'h05);
        rst = 1'b1;
        #2;
        check_output("mid_rst_in_ready", bus.in_bytes_stream_ready, 0);
        check_output("mid_rst_out_valid", bus.out_bytes_stream_valid, 0);
        check_output("mid_rst_led", led, 0);
        check_output("mid_rst_frame_err", frame_err, 0);
        check_output("mid_rst_regs", regs_flat == '0, 1);
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                apply_stimulus(CMD_WR, 8'($urandom_range(0, 9)), $urandom, CSUM && ($urandom_range(0, 4) == 0));
            end else if (r < 8) begin
                apply_stimulus(CMD_RD, 8'($urandom_range(0, 9)), 32'h0, CSUM && ($urandom_range(0, 4) == 0));
            end else begin
                c = 8'($urandom_range(3, 255));
                apply_stimulus(c, 8'h00, 32'h0, 1'b0);
            end
            wait_drain();
            check_regs();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
